// File: rtl/prng_req_arbiter.sv
// prng_req_arbiter
//   Shares one 64-bit xorshift generator (21 left, 35 right, 4 left) among
//   NUM_REQ requesters with round-robin arbitration. Seeding and warm-up are
//   sequenced here, and each grant delivers one fresh generator word.
//
// Ports
//   clk        clock, all logic on posedge
//   rst        synchronous reset, active-low
//   seed_load  one-cycle pulse: load seed_in (zero seed -> DEFAULT_SEED)
//   seed_in    new 64-bit seed
//   req        per-requester level request
//   gnt        registered one-hot grant pulse
//   rnd_valid  high in the cycle rnd_data carries a granted word
//   rnd_data   random word for the granted requester (holds when idle)
//   ready      high while in SERVE state
//   grant_cnt  grants since last reset/reseed, wraps at 2^32
module prng_req_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned WARMUP       = 16,
    parameter logic [63:0] DEFAULT_SEED = 64'h9E3779B97F4A7C15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seed_load,
    input  logic [63:0]        seed_in,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               rnd_valid,
    output logic [63:0]        rnd_data,
    output logic               ready,
    output logic [31:0]        grant_cnt
);

    localparam int unsigned     PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned     CW        = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [CW-1:0]   WARM_LAST = CW'((WARMUP == 0) ? 0 : WARMUP - 1);
    localparam logic [PW-1:0]   PTR_INIT  = PW'(NUM_REQ - 1);

    typedef enum logic {
        ST_WARMUP,
        ST_SERVE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [63:0]     s;
    logic [CW-1:0]   warm_cnt;
    logic            warm_done;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win_idx;
    logic            win_found;
    logic [63:0]     seed_val;

    function automatic logic [63:0] xs_step(input logic [63:0] x);
        logic [63:0] x1;
        logic [63:0] x2;
        x1 = x ^ (x << 21);
        x2 = x1 ^ (x1 >> 35);
        return x2 ^ (x2 << 4);
    endfunction

    // Requester index p+off, wrapped into 0..NUM_REQ-1.
    function automatic logic [PW-1:0] rr_cand(input logic [PW-1:0] p, input int unsigned off);
        int unsigned c;
        c = 32'(p) + off;
        if (c >= NUM_REQ) begin
            c = c - NUM_REQ;
        end
        return PW'(c);
    endfunction

    // A zero state would lock the generator at zero forever.
    assign seed_val  = (seed_in == '0) ? DEFAULT_SEED : seed_in;
    assign warm_done = (WARMUP == 0) || (warm_cnt == WARM_LAST);

    // Search starts one past the last winner; the last candidate is the
    // previous winner itself, so a lone requester is granted back to back.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            if (!win_found && req[rr_cand(ptr, i)]) begin
                win_found = 1'b1;
                win_idx   = rr_cand(ptr, i);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_WARMUP;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (seed_load) begin
            state_next = ST_WARMUP;
        end else begin
            case (state)
                ST_WARMUP: if (warm_done) state_next = ST_SERVE;
                ST_SERVE:  state_next = ST_SERVE;
                default:   state_next = ST_WARMUP;
            endcase
        end
    end

    // Output logic
    always_comb begin
        ready = (state == ST_SERVE);
    end

    // Generator, warm-up counter, arbitration pointer and grant outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            s         <= DEFAULT_SEED;
            warm_cnt  <= '0;
            ptr       <= PTR_INIT;
            gnt       <= '0;
            rnd_valid <= 1'b0;
            rnd_data  <= '0;
            grant_cnt <= '0;
        end else if (seed_load) begin
            s         <= seed_val;
            warm_cnt  <= '0;
            grant_cnt <= '0;
            gnt       <= '0;
            rnd_valid <= 1'b0;
        end else begin
            gnt       <= '0;
            rnd_valid <= 1'b0;
            case (state)
                ST_WARMUP: begin
                    if (WARMUP != 0) begin
                        s        <= xs_step(s);
                        warm_cnt <= warm_cnt + CW'(1);
                    end
                end
                ST_SERVE: begin
                    if (win_found) begin
                        gnt       <= NUM_REQ'(1) << win_idx;
                        rnd_valid <= 1'b1;
                        rnd_data  <= s;
                        s         <= xs_step(s);
                        ptr       <= win_idx;
                        grant_cnt <= grant_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/prng_req_arbiter.md
Name: prng_req_arbiter

Overview:
- Shares one 64-bit xorshift generator (shift triple 21 left, 35 right, 4 left) among NUM_REQ requesters under round-robin arbitration.
- Sequences generator seeding and warm-up, and delivers one random word per grant.
- Sits between the generator state and the hardware cores that consume randomness.

Parameters:
- NUM_REQ, 4, number of requesters, 2..16
- WARMUP, 16, generator steps discarded after every (re)seed; 0 allowed
- DEFAULT_SEED, 64'h9E3779B97F4A7C15, seed used at reset and whenever a zero seed is loaded

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous reset, active-low (rst==0 resets)
- seed_load  in  1  one-cycle pulse: load seed_in
- seed_in  in  64  new seed
- req  in  NUM_REQ  per-requester level request
- gnt  out  NUM_REQ  one-hot grant pulse, registered
- rnd_valid  out  1  high in the cycle rnd_data carries a granted word
- rnd_data  out  64  random word for the granted requester
- ready  out  1  high while in SERVE state
- grant_cnt  out  32  total grants since last reset/reseed, wraps at 2^32

Behaviour:
- Generator state S (64b). step(S) = x1=S^(S<<21); x2=x1^(x1>>35); x3=x2^(x2<<4). All shifts are logical, truncated to 64b.
- FSM states: WARMUP, SERVE.
- Reset (rst==0 at posedge):
  - S<=DEFAULT_SEED; FSM<=WARMUP; warm counter<=0.
  - gnt=0, rnd_valid=0, rnd_data=0, ready=0, grant_cnt=0.
  - RR pointer<=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-operation discards any grant in flight.
- WARMUP:
  - Each cycle S<=step(S) and the counter increments.
  - After WARMUP steps, FSM<=SERVE.
  - If WARMUP==0, leave WARMUP in the next cycle with no steps taken.
  - No grants are issued; req is ignored.
- SERVE: ready=1. In a cycle where req!=0 and seed_load==0:
  - Select winner = first set bit of req searching from pointer+1 upward, wrapping.
  - Next cycle: gnt=onehot(winner), rnd_valid=1, rnd_data=S as sampled.
  - Same edge: S<=step(S), pointer<=winner, grant_cnt+1.
  - One grant maximum per cycle. Grant latency is 1 cycle from req sampled.
- A requester holding req high may be granted on consecutive cycles if it is the only requester. With several requesters held, grants rotate strictly.
- If req==0: gnt=0, rnd_valid=0, rnd_data holds its last value, S is not stepped.
- seed_load (any state) has priority over everything:
  - S<=(seed_in==0 ? DEFAULT_SEED : seed_in); FSM<=WARMUP; counter<=0; grant_cnt<=0.
  - No grant is issued off this cycle; next-cycle gnt=0.
  - Pointer is kept.
- A zero state is never reachable: the zero-seed substitution guarantees this.
- gnt and rnd_valid are never high outside the cycle following a SERVE-state arbitration.
- Words are never duplicated: every granted word is a distinct consecutive generator output.

Test Plan:
- Reset, WARMUP=0, seed_load with seed_in=1, then req=4'b0001 held → first gnt=0001 with rnd_data=64'h1; next gnt=0001 with rnd_data=64'h0000000002200011. rnd_valid is high in both cycles; grant_cnt=2.
- WARMUP=0, seed 1, req=4'b1111 held 8 cycles → gnt sequence 0001,0010,0100,1000,0001,... and rnd_data follows consecutive step() outputs, starting 64'h1. No cycle without a grant.
- seed_load with seed_in=0 → S equals DEFAULT_SEED: first granted word (WARMUP=0) = 64'h9E3779B97F4A7C15.
- WARMUP=16, reset released with req=4'b0010 held → ready=0 and gnt=0 for 16 cycles, then ready=1. The first gnt=0010 arrives one cycle later with rnd_data=step^16(DEFAULT_SEED), matching the reference model.
- In SERVE with req=4'b0011 held, pulse seed_load → gnt=0 the following cycle, ready drops, grant_cnt=0. Grants resume after the WARMUP steps with the first word = step^WARMUP(seed_in).
- Assert rst=0 for one cycle mid-stream → next cycle gnt=0, rnd_valid=0, rnd_data=0, grant_cnt=0. The arbitration pointer restarts at requester 0.
